sensor_frame_packetizer: RTL and testbench

- Upstream neighbour of the 16-to-32-bit ST packer in the sensor algorithm path.
- Takes the free-running 16-bit sensor sample strobe and frames each trigger into one Avalon-ST packet: header word plus FRAME_LEN samples, with SOP and EOP.
- Buffers packets in an internal show-ahead FIFO so downstream backpressure never corrupts a packet; a frame that cannot fit is dropped whole and counted.

---
 rtl/sensor_pkg.sv | 16 +
 rtl/sc_fifo.sv | 53 +++++
 rtl/sensor_frame_packetizer.sv | 124 ++++++++++++
 tb/tb_sensor_frame_packetizer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared types for the sensor algorithm path: sample width, header layout and the ST beat carried by the packet FIFO.
package sensor_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic [3:0] HDR_MAGIC = 4'hA;
  localparam int FRAME_CNT_W = 12;

  typedef struct packed {
    logic                sop;
    logic                eop;
    logic [SAMPLE_W-1:0] data;
  } st_beat_t;

  function automatic logic [SAMPLE_W-1:0] hdr_word(input logic [FRAME_CNT_W-1:0] cnt);
    return {HDR_MAGIC, cnt};
  endfunction
endpackage

// File: rtl/sc_fifo.sv
// Single-clock show-ahead FIFO: rd_data shows the head combinationally, the head pops on rd_en.
// Writes when full and reads when empty are ignored; DEPTH must be a power of two.
module sc_fifo #(
  parameter int WIDTH  = 18,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + ADDR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + ADDR_W'(do_rd);
    count_d  = count_q + (ADDR_W+1)'(do_wr) - (ADDR_W+1)'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/sensor_frame_packetizer.sv
// Frames each trigger into header + FRAME_LEN samples; header lands in the FIFO one edge after frame_start.
// FIFO space is reserved at acceptance, so output backpressure never truncates a packet; unfit frames are dropped whole.
module sensor_frame_packetizer
  import sensor_pkg::*;
#(
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] data_out_data,
  output logic                data_out_valid,
  input  logic                data_out_ready,
  output logic                data_out_startofpacket,
  output logic                data_out_endofpacket,
  output logic [1:0]          data_out_empty,
  output logic                busy,
  output logic [15:0]         drop_cnt,
  output logic                framing_err
);
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, CAPTURE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   framing_err_q, framing_err_d;

  logic                   wr_en, fifo_push, fifo_empty, fifo_full;
  st_beat_t               wr_beat, head;
  logic [ADDR_W:0]        fifo_count;
  logic                   fits;

  // Uses the registered occupancy; a pop in the same cycle is not credited.
  assign fits = (int'(fifo_count) + FRAME_LEN + 1) <= FIFO_DEPTH;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    framing_err_d = framing_err_q;
    wr_en         = 1'b0;
    wr_beat       = '0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          if (fits) begin
            wr_en        = 1'b1;
            wr_beat.sop  = 1'b1;
            wr_beat.data = hdr_word(frame_cnt_q);
            frame_cnt_d  = frame_cnt_q + 1'b1;
            idx_d        = '0;
            state_d      = CAPTURE;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end
        end
      end
      CAPTURE: begin
        if (frame_start) framing_err_d = 1'b1;
        if (sample_valid) begin
          wr_en        = 1'b1;
          wr_beat.eop  = (idx_q == LAST_IDX);
          wr_beat.data = sample_data;
          if (idx_q == LAST_IDX) state_d = IDLE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      drop_cnt_q    <= '0;
      framing_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign fifo_push = wr_en && !fifo_full;

  sc_fifo #(
    .WIDTH  ($bits(st_beat_t)),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (fifo_push),
    .wr_data (wr_beat),
    .rd_en   (data_out_valid && data_out_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  // Head fields are masked when empty so stale storage never shows on the bus.
  assign data_out_valid         = !fifo_empty;
  assign data_out_data          = data_out_valid ? head.data : '0;
  assign data_out_startofpacket = data_out_valid && head.sop;
  assign data_out_endofpacket   = data_out_valid && head.eop;
  assign data_out_empty         = 2'b00;
  assign busy                   = (state_q == CAPTURE);
  assign drop_cnt               = drop_cnt_q;
  assign framing_err            = framing_err_q;
endmodule

// File: tb/tb_sensor_frame_packetizer.sv
// Bench for sensor_frame_packetizer: directed vector table, hand sequences for corner cases, random traffic vs a queue model.
module tb_sensor_frame_packetizer;
  localparam int FL    = 8;
  localparam int DEPTH = 32;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [15:0] data;
  } beat_t;

  typedef struct {
    logic        fs;
    logic        sv;
    logic [15:0] sd;
    logic        exp_busy;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_sop;
    logic        exp_eop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start, sample_valid, data_out_ready;
  logic [15:0] sample_data;
  logic [15:0] data_out_data;
  logic        data_out_valid, data_out_startofpacket, data_out_endofpacket;
  logic [1:0]  data_out_empty;
  logic        busy, framing_err;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sensor_frame_packetizer dut (
    .clk                    (clk),
    .rst                    (rst),
    .frame_start            (frame_start),
    .sample_data            (sample_data),
    .sample_valid           (sample_valid),
    .data_out_data          (data_out_data),
    .data_out_valid         (data_out_valid),
    .data_out_ready         (data_out_ready),
    .data_out_startofpacket (data_out_startofpacket),
    .data_out_endofpacket   (data_out_endofpacket),
    .data_out_empty         (data_out_empty),
    .busy                   (busy),
    .drop_cnt               (drop_cnt),
    .framing_err            (framing_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a queue holding the packet FIFO contents plus frame bookkeeping.
  beat_t mq[$];
  beat_t dut_rx[$];
  bit    m_cap = 0;
  bit    m_ferr = 0;
  int    m_idx = 0;
  int    m_fcnt = 0;
  int    m_drop = 0;

  always @(negedge clk) begin : model
    int    occ;
    beat_t b;
    if (!rst) begin
      mq.delete();
      m_cap = 0; m_idx = 0; m_fcnt = 0; m_drop = 0; m_ferr = 0;
      chk("m_rst_valid", data_out_valid, 0);
      chk("m_rst_sop", data_out_startofpacket, 0);
      chk("m_rst_data", data_out_data, 0);
    end else begin
      chk("m_valid", data_out_valid, mq.size() != 0);
      if (mq.size() != 0 && data_out_valid) begin
        chk("m_data", data_out_data, mq[0].data);
        chk("m_sop", data_out_startofpacket, mq[0].sop);
        chk("m_eop", data_out_endofpacket, mq[0].eop);
      end
      chk("m_busy", busy, m_cap);
      chk("m_drop", drop_cnt, m_drop);
      chk("m_ferr", framing_err, m_ferr);
      chk("m_empty", data_out_empty, 0);
      if (data_out_valid && data_out_ready)
        dut_rx.push_back({data_out_startofpacket, data_out_endofpacket, data_out_data});
      occ = mq.size();
      if (occ != 0 && data_out_ready) void'(mq.pop_front());
      if (!m_cap) begin
        if (frame_start) begin
          if (DEPTH - occ >= FL + 1) begin
            b.sop = 1'b1; b.eop = 1'b0; b.data = 16'hA000 + 16'(m_fcnt);
            mq.push_back(b);
            m_fcnt = (m_fcnt + 1) % 4096;
            m_cap = 1; m_idx = 0;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
      end else begin
        if (frame_start) m_ferr = 1;
        if (sample_valid) begin
          b.sop = 1'b0; b.eop = (m_idx == FL - 1); b.data = sample_data;
          mq.push_back(b);
          m_idx++;
          if (m_idx == FL) m_cap = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      checks++;
      assert (!(dut.wr_en && dut.fifo_full))
      else begin
        errors++;
        $display("FAIL fifo_overflow: write while full actual=1 required=0");
      end
    end
  end

  task automatic cyc(input logic fs, input logic sv, input logic [15:0] sd);
    frame_start = fs; sample_valid = sv; sample_data = sd;
    @(posedge clk); #1;
    frame_start = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 16'h0);
  endtask

  task automatic frame();
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= FL; i++) cyc(1'b0, 1'b1, 16'(i));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_pkt(input string nm, input int off, input logic [15:0] hdr);
    chk({nm, "_len"}, dut_rx.size() >= off + FL + 1, 1);
    if (dut_rx.size() >= off + FL + 1) begin
      for (int k = 0; k <= FL; k++) begin
        chk($sformatf("%s_b%0d_data", nm, k), dut_rx[off+k].data, (k == 0) ? hdr : 16'(k));
        chk($sformatf("%s_b%0d_sop", nm, k), dut_rx[off+k].sop, k == 0);
        chk($sformatf("%s_b%0d_eop", nm, k), dut_rx[off+k].eop, k == FL);
      end
    end
  endtask

  vec_t tv[FL+2];
  int   sops;

  initial begin
    rst = 1'b0; frame_start = 1'b0; sample_valid = 1'b0; sample_data = 16'h0;
    data_out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", data_out_data, 0);
    chk("rst_sop", data_out_startofpacket, 0);
    chk("rst_eop", data_out_endofpacket, 0);
    chk("rst_empty", data_out_empty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_ferr", framing_err, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Scenario 1: vector table, ready held high
    tv[0] = '{1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'hA000, 1'b1, 1'b0};
    for (int i = 1; i <= FL; i++)
      tv[i] = '{1'b0, 1'b1, 16'(i), (i != FL), 1'b1, 16'(i), 1'b0, (i == FL)};
    tv[FL+1] = '{1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0};
    for (int i = 0; i < FL + 2; i++) begin
      cyc(tv[i].fs, tv[i].sv, tv[i].sd);
      chk($sformatf("s1_v%0d_busy", i), busy, tv[i].exp_busy);
      chk($sformatf("s1_v%0d_valid", i), data_out_valid, tv[i].exp_valid);
      chk($sformatf("s1_v%0d_data", i), data_out_data, tv[i].exp_data);
      chk($sformatf("s1_v%0d_sop", i), data_out_startofpacket, tv[i].exp_sop);
      chk($sformatf("s1_v%0d_eop", i), data_out_endofpacket, tv[i].exp_eop);
    end

    // Scenario 2: three frames fill 27 entries, fourth is dropped
    do_reset();
    data_out_ready = 1'b0;
    repeat (3) frame();
    cyc(1'b1, 1'b0, 16'h0);
    chk("s2_drop", drop_cnt, 1);
    chk("s2_busy", busy, 0);
    chk("s2_head", data_out_data, 16'hA000);
    dut_rx.delete();
    data_out_ready = 1'b1;
    idle(40);
    chk("s2_beats", dut_rx.size(), 3 * (FL + 1));
    check_pkt("s2_p0", 0, 16'hA000);
    check_pkt("s2_p1", FL + 1, 16'hA001);
    check_pkt("s2_p2", 2 * (FL + 1), 16'hA002);
    sops = 0;
    foreach (dut_rx[k]) if (dut_rx[k].sop) sops++;
    chk("s2_sops", sops, 3);

    // Scenario 3: ready toggles during a frame
    dut_rx.delete();
    data_out_ready = 1'b0;
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= FL; i++) begin
      data_out_ready = i[0];
      cyc(1'b0, 1'b1, 16'(i));
    end
    for (int i = 0; i < 24; i++) begin
      data_out_ready = i[0];
      cyc(1'b0, 1'b0, 16'h0);
    end
    data_out_ready = 1'b1;
    idle(4);
    chk("s3_beats", dut_rx.size(), FL + 1);
    check_pkt("s3", 0, 16'hA003);

    // Scenario 4: same-cycle start+sample in IDLE, then a stray start mid-capture
    dut_rx.delete();
    cyc(1'b1, 1'b1, 16'hDEAD);
    for (int i = 1; i <= FL; i++) cyc((i == 4), 1'b1, 16'(i));
    idle(4);
    chk("s4_ferr", framing_err, 1);
    chk("s4_beats", dut_rx.size(), FL + 1);
    check_pkt("s4", 0, 16'hA004);
    cyc(1'b1, 1'b0, 16'h0);
    chk("s4_next_hdr", data_out_data, 16'hA005);
    chk("s4_next_sop", data_out_startofpacket, 1);
    for (int i = 1; i <= FL; i++) cyc(1'b0, 1'b1, 16'(i));
    idle(4);

    // Scenario 5: reset in the middle of capture
    dut_rx.delete();
    data_out_ready = 1'b0;
    cyc(1'b1, 1'b0, 16'h0);
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 16'(i));
    rst = 1'b0;
    #1;
    chk("s5_valid", data_out_valid, 0);
    chk("s5_busy", busy, 0);
    chk("s5_ferr", framing_err, 0);
    chk("s5_drop", drop_cnt, 0);
    @(posedge clk); #1 rst = 1'b1;
    data_out_ready = 1'b1;
    idle(2);
    chk("s5_idle_valid", data_out_valid, 0);
    frame();
    idle(4);
    chk("s5_beats", dut_rx.size(), FL + 1);
    check_pkt("s5", 0, 16'hA000);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      data_out_ready = ($urandom_range(9) < 6);
      cyc(($urandom_range(11) == 0), ($urandom_range(9) < 7), 16'($urandom));
    end
    data_out_ready = 1'b1;
    idle(40);
    chk("rand_drained", data_out_valid, 0);

    // Scenario 6a: frame counter wrap
    do_reset();
    data_out_ready = 1'b1;
    for (int f = 0; f < 4095; f++) begin
      frame();
      if (f[7:0] == 8'hFF) dut_rx.delete();
    end
    idle(4);
    dut_rx.delete();
    frame();
    frame();
    idle(12);
    check_pkt("s6_last", 0, 16'hAFFF);
    check_pkt("s6_wrap", FL + 1, 16'hA000);

    // Scenario 6b: drop counter saturation
    data_out_ready = 1'b0;
    repeat (3) frame();
    frame_start = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    chk("s6_drop_fffe", drop_cnt, 16'hFFFE);
    repeat (6) @(posedge clk);
    #1;
    frame_start = 1'b0;
    chk("s6_drop_sat", drop_cnt, 16'hFFFF);
    chk("s6_busy", busy, 0);
    data_out_ready = 1'b1;
    idle(40);
    chk("s6_drained", data_out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
